// File: rtl/i2cmb_wb_sequencer_if.sv
// ---------------------------------------------------------------------------
// i2cmb_wb_sequencer_if
// Wishbone register-port bundle between the sequencer (master) and the
// iicmb_m_wb controller (slave).
//   cyc_o/stb_o/we_o : master cycle, strobe and write-enable
//   adr_o            : register address (0=CSR, 1=DPR, 2=CMDR, 3=FSMR)
//   dat_o / dat_i    : write data from master / read data from slave
//   ack_i            : slave acknowledge
//   irq_i            : controller interrupt (command complete)
// ---------------------------------------------------------------------------
interface i2cmb_wb_sequencer_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic              cyc_o;
  logic              stb_o;
  logic              we_o;
  logic [ADDR_W-1:0] adr_o;
  logic [DATA_W-1:0] dat_o;
  logic [DATA_W-1:0] dat_i;
  logic              ack_i;
  logic              irq_i;

  modport master (output cyc_o, stb_o, we_o, adr_o, dat_o,
                  input  dat_i, ack_i, irq_i);
  modport slave  (input  cyc_o, stb_o, we_o, adr_o, dat_o,
                  output dat_i, ack_i, irq_i);
endinterface

// File: rtl/i2cmb_wb_sequencer.sv
// ---------------------------------------------------------------------------
// i2cmb_wb_sequencer
// Wishbone master that turns one high-level I2C request into the CSR/DPR/CMDR
// register accesses of the iicmb_m_wb controller, with IRQ-driven completion.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_*                 : transaction request (bus, address, rw, length)
//   wdata_* / rdata_*     : write-byte and read-byte stream handshakes
//   done / status         : one-cycle end pulse and held result code
//   wb                    : Wishbone master port plus controller irq
// ---------------------------------------------------------------------------
module i2cmb_wb_sequencer #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int LEN_WIDTH      = 6,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [3:0]                req_bus_id,
  input  logic [I2C_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_rw,
  input  logic [LEN_WIDTH-1:0]      req_len,
  input  logic                      wdata_valid,
  output logic                      wdata_ready,
  input  logic [WB_DATA_WIDTH-1:0]  wdata,
  output logic                      rdata_valid,
  input  logic                      rdata_ready,
  output logic [WB_DATA_WIDTH-1:0]  rdata,
  output logic                      done,
  output logic [2:0]                status,
  i2cmb_wb_sequencer_if.master      wb
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(2'd0);
  localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(2'd1);
  localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2'd2);

  localparam logic [WB_DATA_WIDTH-1:0] CSR_ON    = WB_DATA_WIDTH'(8'hC0);
  localparam logic [WB_DATA_WIDTH-1:0] CSR_OFF   = WB_DATA_WIDTH'(8'h00);
  localparam logic [WB_DATA_WIDTH-1:0] CMD_WRITE = WB_DATA_WIDTH'(8'h01);
  localparam logic [WB_DATA_WIDTH-1:0] CMD_RDACK = WB_DATA_WIDTH'(8'h02);
  localparam logic [WB_DATA_WIDTH-1:0] CMD_RDNAK = WB_DATA_WIDTH'(8'h03);
  localparam logic [WB_DATA_WIDTH-1:0] CMD_START = WB_DATA_WIDTH'(8'h04);
  localparam logic [WB_DATA_WIDTH-1:0] CMD_STOP  = WB_DATA_WIDTH'(8'h05);
  localparam logic [WB_DATA_WIDTH-1:0] CMD_SETBUS= WB_DATA_WIDTH'(8'h06);

  localparam logic [2:0] ST_OK = 3'd0, ST_ANAK = 3'd1, ST_DNAK = 3'd2,
                         ST_AL = 3'd3, ST_ERR  = 3'd4, ST_TO   = 3'd5;

  localparam logic [4:0] S_INIT = 5'd0,  S_IDLE = 5'd1,  S_BUS_DPR = 5'd2,
                         S_BUS_CMD = 5'd3, S_START = 5'd4, S_ADDR_DPR = 5'd5,
                         S_ADDR_CMD = 5'd6, S_WR_GET = 5'd7, S_WR_DPR = 5'd8,
                         S_WR_CMD = 5'd9, S_RD_CMD = 5'd10, S_RD_DPR = 5'd11,
                         S_RD_OUT = 5'd12, S_STOP = 5'd13, S_WAIT = 5'd14,
                         S_CMDR_RD = 5'd15, S_TO_OFF = 5'd16, S_TO_ON = 5'd17,
                         S_DONE = 5'd18;

  // Which command is outstanding, so the CMDR status can be interpreted.
  localparam logic [2:0] K_BUS = 3'd0, K_START = 3'd1, K_ADDR = 3'd2,
                         K_WR  = 3'd3, K_RD    = 3'd4, K_STOP = 3'd5;

  logic [4:0]                state_q, state_d;
  logic [2:0]                kind_q, kind_d;
  logic                      cyc_q, cyc_d, we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0]  adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0]  dat_q, dat_d;
  logic                      req_ready_q, req_ready_d;
  logic                      wdata_ready_q, wdata_ready_d;
  logic                      rdata_valid_q, rdata_valid_d;
  logic [WB_DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                      done_q, done_d;
  logic [2:0]                status_q, status_d, stat_q, stat_d;
  logic [3:0]                bid_q, bid_d, bus_q, bus_d;
  logic                      bus_valid_q, bus_valid_d;
  logic [I2C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      rw_q, rw_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d, cnt_q, cnt_d;
  logic [WB_DATA_WIDTH-1:0]  wbyte_q, wbyte_d;
  logic [TO_W-1:0]           to_cnt_q, to_cnt_d;

  logic                      acc_en_s, acc_we_s, acc_done_s, last_s;
  logic [WB_ADDR_WIDTH-1:0]  acc_adr_s;
  logic [WB_DATA_WIDTH-1:0]  acc_dat_s;

  assign acc_done_s = cyc_q & wb.ack_i;
  assign last_s     = (cnt_q == (len_q - LEN_WIDTH'(1)));

  // Register access requested by the current state (at most one per state).
  always_comb begin
    acc_en_s  = 1'b0;
    acc_we_s  = 1'b1;
    acc_adr_s = A_CSR;
    acc_dat_s = CSR_OFF;
    case (state_q)
      S_INIT, S_TO_ON: begin acc_en_s = 1'b1; acc_dat_s = CSR_ON; end
      S_TO_OFF:   begin acc_en_s = 1'b1; acc_dat_s = CSR_OFF; end
      S_BUS_DPR:  begin acc_en_s = 1'b1; acc_adr_s = A_DPR;  acc_dat_s = WB_DATA_WIDTH'(bid_q); end
      S_BUS_CMD:  begin acc_en_s = 1'b1; acc_adr_s = A_CMDR; acc_dat_s = CMD_SETBUS; end
      S_START:    begin acc_en_s = 1'b1; acc_adr_s = A_CMDR; acc_dat_s = CMD_START; end
      S_ADDR_DPR: begin acc_en_s = 1'b1; acc_adr_s = A_DPR;  acc_dat_s = WB_DATA_WIDTH'({addr_q, rw_q}); end
      S_ADDR_CMD, S_WR_CMD:
                  begin acc_en_s = 1'b1; acc_adr_s = A_CMDR; acc_dat_s = CMD_WRITE; end
      S_WR_DPR:   begin acc_en_s = 1'b1; acc_adr_s = A_DPR;  acc_dat_s = wbyte_q; end
      S_RD_CMD: begin
        acc_en_s  = 1'b1;
        acc_adr_s = A_CMDR;
        if (last_s) begin
          acc_dat_s = CMD_RDNAK;
        end else begin
          acc_dat_s = CMD_RDACK;
        end
      end
      S_RD_DPR:   begin acc_en_s = 1'b1; acc_we_s = 1'b0; acc_adr_s = A_DPR; end
      S_STOP:     begin acc_en_s = 1'b1; acc_adr_s = A_CMDR; acc_dat_s = CMD_STOP; end
      S_CMDR_RD:  begin acc_en_s = 1'b1; acc_we_s = 1'b0; acc_adr_s = A_CMDR; end
      default:    acc_en_s = 1'b0;
    endcase
  end

  // Wishbone cycle engine, sequencer FSM and output/next-state computation.
  always_comb begin
    state_d = state_q;  kind_d = kind_q;
    cyc_d = cyc_q;  we_d = we_q;  adr_d = adr_q;  dat_d = dat_q;
    wdata_ready_d = 1'b0;  rdata_valid_d = rdata_valid_q;  rdata_d = rdata_q;
    done_d = 1'b0;  status_d = status_q;  stat_d = stat_q;
    bid_d = bid_q;  bus_d = bus_q;  bus_valid_d = bus_valid_q;
    addr_d = addr_q;  rw_d = rw_q;  len_d = len_q;  cnt_d = cnt_q;
    wbyte_d = wbyte_q;  to_cnt_d = '0;

    // An ack ends the access; the following cycle is always idle because a
    // new access is only launched while cyc is low.
    if (cyc_q) begin
      if (wb.ack_i) begin
        cyc_d = 1'b0;
      end else begin
        cyc_d = 1'b1;
      end
    end else if (acc_en_s) begin
      cyc_d = 1'b1;  we_d = acc_we_s;  adr_d = acc_adr_s;  dat_d = acc_dat_s;
    end else begin
      cyc_d = 1'b0;
    end

    case (state_q)
      S_INIT, S_TO_ON: begin
        if (acc_done_s) begin
          state_d = (state_q == S_INIT) ? S_IDLE : S_DONE;
        end else begin
          state_d = state_q;
        end
      end
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          bid_d = req_bus_id;  addr_d = req_addr;  rw_d = req_rw;
          len_d = req_len;  cnt_d = '0;  stat_d = ST_OK;
          if (!bus_valid_q || (req_bus_id != bus_q)) begin
            state_d = S_BUS_DPR;
          end else begin
            state_d = S_START;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUS_DPR:  if (acc_done_s) state_d = S_BUS_CMD;  else state_d = state_q;
      S_ADDR_DPR: if (acc_done_s) state_d = S_ADDR_CMD; else state_d = state_q;
      S_WR_DPR:   if (acc_done_s) state_d = S_WR_CMD;   else state_d = state_q;
      S_TO_OFF:   if (acc_done_s) state_d = S_TO_ON;    else state_d = state_q;
      S_BUS_CMD, S_START, S_ADDR_CMD, S_WR_CMD, S_RD_CMD, S_STOP: begin
        if (acc_done_s) begin
          state_d = S_WAIT;
          case (state_q)
            S_BUS_CMD:  kind_d = K_BUS;
            S_START:    kind_d = K_START;
            S_ADDR_CMD: kind_d = K_ADDR;
            S_WR_CMD:   kind_d = K_WR;
            S_RD_CMD:   kind_d = K_RD;
            default:    kind_d = K_STOP;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      S_WR_GET: begin
        // Ready is raised for one cycle only once a byte is on offer.
        if (wdata_ready_q) begin
          if (wdata_valid) begin
            wbyte_d = wdata;
            state_d = S_WR_DPR;
          end else begin
            state_d = S_WR_GET;
          end
        end else if (wdata_valid) begin
          wdata_ready_d = 1'b1;
        end else begin
          wdata_ready_d = 1'b0;
        end
      end
      S_RD_DPR: begin
        if (acc_done_s) begin
          rdata_d = wb.dat_i;  rdata_valid_d = 1'b1;  state_d = S_RD_OUT;
        end else begin
          state_d = S_RD_DPR;
        end
      end
      S_RD_OUT: begin
        if (rdata_valid_q && rdata_ready) begin
          rdata_valid_d = 1'b0;
          cnt_d = cnt_q + LEN_WIDTH'(1);
          state_d = ((cnt_q + LEN_WIDTH'(1)) == len_q) ? S_STOP : S_RD_CMD;
        end else begin
          state_d = S_RD_OUT;
        end
      end
      S_WAIT: begin
        if (wb.irq_i) begin
          state_d = S_CMDR_RD;
        end else if (to_cnt_q == TO_LAST) begin
          stat_d = ST_TO;  bus_valid_d = 1'b0;  state_d = S_TO_OFF;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_CMDR_RD: begin
        if (!acc_done_s) begin
          state_d = S_CMDR_RD;
        end else if (wb.dat_i[7]) begin
          case (kind_q)
            K_BUS:   begin bus_d = bid_q; bus_valid_d = 1'b1; state_d = S_START; end
            K_START: state_d = S_ADDR_DPR;
            K_ADDR: begin
              if (len_q == '0) begin
                state_d = S_STOP;
              end else if (rw_q) begin
                state_d = S_RD_CMD;
              end else begin
                state_d = S_WR_GET;
              end
            end
            K_WR: begin
              cnt_d = cnt_q + LEN_WIDTH'(1);
              state_d = ((cnt_q + LEN_WIDTH'(1)) == len_q) ? S_STOP : S_WR_GET;
            end
            K_RD:    state_d = S_RD_DPR;
            default: state_d = S_DONE;
          endcase
        end else if (wb.dat_i[5]) begin
          // Arbitration lost: the bus is no longer ours, so no stop.
          stat_d = ST_AL;  state_d = S_DONE;
        end else begin
          if (wb.dat_i[6]) begin
            stat_d = (kind_q == K_ADDR) ? ST_ANAK : ST_DNAK;
          end else begin
            stat_d = ST_ERR;
          end
          // A failing stop must not loop back into another stop.
          state_d = (kind_q == K_STOP) ? S_DONE : S_STOP;
        end
      end
      S_DONE: begin
        done_d = 1'b1;  status_d = stat_q;  state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    // Ready is withheld in the cycle of the done pulse so the two never overlap.
    req_ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_INIT;  kind_q <= K_BUS;
      cyc_q <= 1'b0;  we_q <= 1'b0;  adr_q <= '0;  dat_q <= '0;
      req_ready_q <= 1'b0;  wdata_ready_q <= 1'b0;  rdata_valid_q <= 1'b0;
      rdata_q <= '0;  done_q <= 1'b0;  status_q <= ST_OK;  stat_q <= ST_OK;
      bid_q <= 4'd0;  bus_q <= 4'd0;  bus_valid_q <= 1'b0;
      addr_q <= '0;  rw_q <= 1'b0;  len_q <= '0;  cnt_q <= '0;
      wbyte_q <= '0;  to_cnt_q <= '0;
    end else begin
      state_q <= state_d;  kind_q <= kind_d;
      cyc_q <= cyc_d;  we_q <= we_d;  adr_q <= adr_d;  dat_q <= dat_d;
      req_ready_q <= req_ready_d;  wdata_ready_q <= wdata_ready_d;
      rdata_valid_q <= rdata_valid_d;  rdata_q <= rdata_d;
      done_q <= done_d;  status_q <= status_d;  stat_q <= stat_d;
      bid_q <= bid_d;  bus_q <= bus_d;  bus_valid_q <= bus_valid_d;
      addr_q <= addr_d;  rw_q <= rw_d;  len_q <= len_d;  cnt_q <= cnt_d;
      wbyte_q <= wbyte_d;  to_cnt_q <= to_cnt_d;
    end
  end

  assign wb.cyc_o     = cyc_q;
  assign wb.stb_o     = cyc_q;
  assign wb.we_o      = we_q;
  assign wb.adr_o     = adr_q;
  assign wb.dat_o     = dat_q;
  assign req_ready    = req_ready_q;
  assign wdata_ready  = wdata_ready_q;
  assign rdata_valid  = rdata_valid_q;
  assign rdata        = rdata_q;
  assign done         = done_q;
  assign status       = status_q;

endmodule
